jtkicker_psgwr: RTL and testbench

JTKICKER_PSGWR -- requirements
Module: jtkicker_psgwr

---
 rtl/jtkicker_pkg.sv | 18 +
 rtl/jtkicker_psgwr_ch.sv | 117 +++++++++++
 rtl/jtkicker_psgwr.sv | 49 ++++
 tb/tb_jtkicker_psgwr.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkicker_pkg.sv
// Shared encodings and parameter limits for the
// buffered SN76489 write path.
package jtkicker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        BUSY   = 2'd2
    } psg_st_t;

    localparam int CH_MIN    = 1;
    localparam int CH_MAX    = 4;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;
    localparam int TOUT_MIN  = 4;
    localparam int TOUT_MAX  = 255;

endpackage

// File: rtl/jtkicker_psgwr_ch.sv
// One PSG channel: holding register, command FIFO,
// write strobe sequencer and ready timeout.
module jtkicker_psgwr_ch
    import jtkicker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TOUT  = 32
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_cen,
    input  logic [7:0] cpu_dout,
    input  logic       data_cs,
    input  logic       wr_cs,
    input  logic       psg_cen,
    input  logic       psg_rdy,
    output logic       psg_cs_n,
    output logic [7:0] psg_din,
    output logic       full,
    output logic       empty,
    output logic       tout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]  TOUT_LAST = 8'(TOUT - 1);

    psg_st_t       st, st_nx;
    logic [7:0]    hold;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [7:0]    tcnt, tcnt_nx;
    logic          push, pop, load, tout_hit;
    logic [7:0]    push_data;

    assign full      = cnt == FULL_CNT;
    assign empty     = cnt == '0;
    assign push      = cpu_cen & wr_cs & ~full;
    assign push_data = data_cs ? cpu_dout : hold;

    always_comb begin
        st_nx    = st;
        tcnt_nx  = tcnt;
        pop      = 1'b0;
        load     = 1'b0;
        tout_hit = 1'b0;
        unique case (st)
            IDLE: begin
                if (!empty) begin
                    load  = 1'b1;
                    st_nx = STROBE;
                end
            end
            STROBE: begin
                if (psg_cen) st_nx = BUSY;
            end
            BUSY: begin
                if (psg_cen) begin
                    if (psg_rdy) begin
                        pop     = 1'b1;
                        tcnt_nx = '0;
                        st_nx   = IDLE;
                    end else if (tcnt == TOUT_LAST) begin
                        pop      = 1'b1;
                        tout_hit = 1'b1;
                        tcnt_nx  = '0;
                        st_nx    = IDLE;
                    end else begin
                        tcnt_nx = tcnt + 8'd1;
                    end
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    // cs_n is registered from the next state so it never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            tcnt     <= '0;
            psg_cs_n <= 1'b1;
            psg_din  <= '0;
            tout_err <= 1'b0;
        end else begin
            st       <= st_nx;
            tcnt     <= tcnt_nx;
            psg_cs_n <= st_nx != STROBE;
            if (load)     psg_din  <= mem[rd_ptr];
            if (tout_hit) tout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (cpu_cen && data_cs) hold <= cpu_dout;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/jtkicker_psgwr.sv
// Buffered CPU-to-PSG write path: one independent
// command queue per sound chip.
module jtkicker_psgwr
    import jtkicker_pkg::*;
#(
    parameter int CH    = 2,
    parameter int DEPTH = 4,
    parameter int TOUT  = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_cen,
    input  logic [7:0]      cpu_dout,
    input  logic [CH-1:0]   data_cs,
    input  logic [CH-1:0]   wr_cs,
    input  logic [CH-1:0]   psg_cen,
    input  logic [CH-1:0]   psg_rdy,
    output logic [CH-1:0]   psg_cs_n,
    output logic [8*CH-1:0] psg_din,
    output logic            wait_n,
    output logic [CH-1:0]   full,
    output logic [CH-1:0]   empty,
    output logic [CH-1:0]   tout_err
);

    assign wait_n = ~|(wr_cs & full);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        jtkicker_psgwr_ch #(
            .DEPTH (DEPTH),
            .TOUT  (TOUT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .cpu_cen  (cpu_cen),
            .cpu_dout (cpu_dout),
            .data_cs  (data_cs[k]),
            .wr_cs    (wr_cs[k]),
            .psg_cen  (psg_cen[k]),
            .psg_rdy  (psg_rdy[k]),
            .psg_cs_n (psg_cs_n[k]),
            .psg_din  (psg_din[8*k +: 8]),
            .full     (full[k]),
            .empty    (empty[k]),
            .tout_err (tout_err[k])
        );
    end

endmodule

// File: tb/tb_jtkicker_psgwr.sv
// Bench for jtkicker_psgwr: queue-based reference model
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_jtkicker_psgwr;

    localparam int DEPTH = 4;
    localparam int TOUT  = 32;

    logic        clk = 0, rst = 1, cpu_cen = 1;
    logic [7:0]  cpu_dout = 0;
    logic [1:0]  data_cs = 0, wr_cs = 0, psg_rdy = 2'b11;
    logic [1:0]  cen_gen = 0, cen_man = 0, cen_auto = 2'b11;
    logic [1:0]  psg_cen, psg_cs_n, full, empty, tout_err;
    logic [15:0] psg_din;
    logic        wait_n;

    logic [0:0]  d2_data_cs = 0, d2_wr_cs = 0;
    logic [0:0]  d2_cs_n, d2_full, d2_empty, d2_err;
    logic [7:0]  d2_din;
    logic        d2_wait_n;

    assign psg_cen = (cen_auto & cen_gen) | (~cen_auto & cen_man);

    always #5 clk = ~clk;

    jtkicker_psgwr #(.CH(2), .DEPTH(DEPTH), .TOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen),
        .cpu_dout(cpu_dout), .data_cs(data_cs),
        .wr_cs(wr_cs), .psg_cen(psg_cen),
        .psg_rdy(psg_rdy), .psg_cs_n(psg_cs_n),
        .psg_din(psg_din), .wait_n(wait_n),
        .full(full), .empty(empty), .tout_err(tout_err)
    );

    jtkicker_psgwr #(.CH(1), .DEPTH(2), .TOUT(4)) dut2 (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen),
        .cpu_dout(cpu_dout), .data_cs(d2_data_cs),
        .wr_cs(d2_wr_cs), .psg_cen(cen_gen[0:0]),
        .psg_rdy(1'b1), .psg_cs_n(d2_cs_n),
        .psg_din(d2_din), .wait_n(d2_wait_n),
        .full(d2_full), .empty(d2_empty), .tout_err(d2_err)
    );

    int d0 = 0, d1 = 0;
    always @(posedge clk) begin
        #2;
        d0 = (d0 == 2) ? 0 : d0 + 1;
        d1 = (d1 == 3) ? 0 : d1 + 1;
        cen_gen = {d1 == 0, d0 == 0};
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // reference model: queue of pending bytes per channel
    logic [7:0] mq [2][$];
    logic [7:0] mhold [2];
    logic [7:0] mdin [2];
    int         mph [2];
    int         mmiss [2];
    logic [1:0] merr;
    int         coin = 0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mhold[k] = 0;
            mdin[k]  = 0;
            mph[k]   = 0;
            mmiss[k] = 0;
        end
        merr = 0;
    endfunction

    function automatic void model_step(int k);
        int n = mq[k].size();
        logic [7:0] pd = data_cs[k] ? cpu_dout : mhold[k];
        bit go = cpu_cen && wr_cs[k] && n < DEPTH;
        bit pop = 0;
        if (cpu_cen && data_cs[k]) mhold[k] = cpu_dout;
        if (mph[k] == 0) begin
            if (n > 0) begin
                mdin[k] = mq[k][0];
                mph[k] = 1;
            end
        end else if (mph[k] == 1) begin
            if (psg_cen[k]) mph[k] = 2;
        end else if (psg_cen[k]) begin
            if (psg_rdy[k]) pop = 1;
            else begin
                mmiss[k]++;
                if (mmiss[k] == TOUT) begin
                    pop = 1;
                    merr[k] = 1;
                end
            end
        end
        if (pop && go && n == 2) coin++;
        if (pop) begin
            void'(mq[k].pop_front());
            mph[k] = 0;
            mmiss[k] = 0;
        end
        if (go) mq[k].push_back(pd);
    endfunction

    always @(posedge clk) begin
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    logic [7:0] lg [3][$];
    int   lowcnt [2];
    logic [1:0] prev_cs = 2'b11;
    logic d2_prev = 1, d2_full_seen = 0;
    int   tr_st = 0, tr_cnt = 0;

    always @(negedge clk) begin
        logic [1:0]  ecs, efull, eempty, eerr;
        logic [15:0] edin;
        for (int k = 0; k < 2; k++) begin
            ecs[k]    = rst ? 1'b1 : (mph[k] != 1);
            edin[8*k +: 8] = rst ? 8'h00 : mdin[k];
            efull[k]  = rst ? 1'b0 : mq[k].size() == DEPTH;
            eempty[k] = rst ? 1'b1 : mq[k].size() == 0;
            eerr[k]   = rst ? 1'b0 : merr[k];
        end
        chk("m_cs_n", 32'(psg_cs_n), 32'(ecs));
        chk("m_din", 32'(psg_din), 32'(edin));
        chk("m_full", 32'(full), 32'(efull));
        chk("m_empty", 32'(empty), 32'(eempty));
        chk("m_tout", 32'(tout_err), 32'(eerr));
        chk("m_wait_n", 32'(wait_n),
            32'(!(|(wr_cs & efull))));
        for (int k = 0; k < 2; k++) begin
            if (!psg_cs_n[k]) begin
                lowcnt[k]++;
                if (prev_cs[k])
                    lg[k].push_back(psg_din[8*k +: 8]);
            end
        end
        prev_cs = psg_cs_n;
        if (!d2_cs_n[0] && d2_prev) lg[2].push_back(d2_din);
        d2_prev = d2_cs_n[0];
        if (d2_full[0]) d2_full_seen = 1;
        if (tr_st == 1 && !psg_cs_n[1] && psg_cen[1])
            tr_st = 2;
        else if (tr_st == 2) begin
            if (empty[1]) tr_st = 3;
            else if (psg_cen[1]) tr_cnt++;
        end
    end

    function automatic logic [31:0] lget(int k, int i);
        if (i < lg[k].size()) return 32'(lg[k][i]);
        return 32'hDEAD;
    endfunction

    task automatic lclear();
        for (int k = 0; k < 3; k++) lg[k].delete();
        lowcnt[0] = 0;
        lowcnt[1] = 0;
        d2_full_seen = 0;
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic accept();
        int b = 0;
        @(negedge clk);
        while (!wait_n && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk("accept", 32'(wait_n), 32'(1));
        @(posedge clk);
        #2;
        data_cs = 0;
        wr_cs = 0;
    endtask

    task automatic push_main(int k, logic [7:0] d, bit byp);
        cpu_dout = d;
        wr_cs[k] = 1;
        data_cs[k] = byp;
        accept();
    endtask

    task automatic push_d2(logic [7:0] d);
        int b = 0;
        cpu_dout = d;
        d2_wr_cs = 1;
        d2_data_cs = 1;
        @(negedge clk);
        while (!d2_wait_n && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk("d2_accept", 32'(d2_wait_n), 32'(1));
        @(posedge clk);
        #2;
        d2_wr_cs = 0;
        d2_data_cs = 0;
    endtask

    task automatic chk_reset(string pfx);
        chk({pfx, "_cs_n"}, 32'(psg_cs_n), 32'(2'b11));
        chk({pfx, "_din"}, 32'(psg_din), 32'(0));
        chk({pfx, "_empty"}, 32'(empty), 32'(2'b11));
        chk({pfx, "_full"}, 32'(full), 32'(0));
        chk({pfx, "_tout"}, 32'(tout_err), 32'(0));
        chk({pfx, "_wait_n"}, 32'(wait_n), 32'(1));
    endtask

    initial begin
        @(negedge clk);
        chk_reset("rst0");
        @(posedge clk);
        #2;
        rst = 0;
        cyc(2);

        // latched data then separate write strobe
        lclear();
        data_cs[0] = 1;
        cpu_dout = 8'h9F;
        cyc(1);
        data_cs[0] = 0;
        cpu_dout = 8'h00;
        wr_cs[0] = 1;
        cyc(1);
        wr_cs[0] = 0;
        @(negedge clk);
        chk("lat_1clk", 32'(psg_cs_n[0]), 32'(1));
        @(negedge clk);
        chk("lat_2clk", 32'(psg_cs_n[0]), 32'(0));
        chk("lat_din", 32'(psg_din[7:0]), 32'(8'h9F));
        cyc(20);
        chk("t1_n", lg[0].size(), 1);
        chk("t1_byte", lget(0, 0), 32'(8'h9F));
        chk("t1_win", 32'(lowcnt[0] >= 1 && lowcnt[0] <= 3),
            32'(1));
        chk("t1_empty", 32'(empty[0]), 32'(1));

        // bypass must beat a stale hold value
        lclear();
        data_cs[1] = 1;
        cpu_dout = 8'h11;
        cyc(1);
        wr_cs[1] = 1;
        cpu_dout = 8'hBF;
        cyc(1);
        data_cs[1] = 0;
        wr_cs[1] = 0;
        cyc(20);
        chk("t2_n", lg[1].size(), 1);
        chk("t2_byte", lget(1, 0), 32'(8'hBF));
        chk("t2_din", 32'(psg_din[15:8]), 32'(8'hBF));

        // strobes without cpu_cen are ignored
        lclear();
        cpu_cen = 0;
        data_cs[1] = 1;
        wr_cs[1] = 1;
        cpu_dout = 8'h77;
        cyc(1);
        data_cs = 0;
        wr_cs = 0;
        cpu_cen = 1;
        cyc(10);
        chk("cen_gate_n", lg[1].size(), 0);
        chk("cen_gate_e", 32'(empty[1]), 32'(1));
        push_main(1, 8'h00, 0);
        cyc(15);
        chk("hold_kept", lget(1, 0), 32'(8'hBF));

        // fill, back-pressure, ordered drain
        lclear();
        psg_rdy[0] = 0;
        for (int i = 0; i < 4; i++)
            push_main(0, 8'(8'h80 + i), 1);
        @(negedge clk);
        chk("t3_full", 32'(full[0]), 32'(1));
        @(posedge clk);
        #2;
        cpu_dout = 8'h84;
        data_cs[0] = 1;
        wr_cs[0] = 1;
        @(negedge clk);
        chk("t3_wait_n", 32'(wait_n), 32'(0));
        @(posedge clk);
        #2;
        psg_rdy[0] = 1;
        accept();
        cyc(60);
        chk("t3_n", lg[0].size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t3_order", lget(0, i), 32'(8'h80 + i));

        // timeout on ch1 while ch0 keeps working
        lclear();
        psg_rdy = 2'b01;
        tr_cnt = 0;
        tr_st = 1;
        push_main(1, 8'h55, 1);
        for (int i = 0; i < 3; i++) begin
            push_main(0, 8'(8'hA0 + i), 1);
            cyc(5);
        end
        for (int b = 0; b < 400 && tr_st != 3; b++) cyc(1);
        chk("t4_pulses", tr_cnt, TOUT);
        chk("t4_err", 32'(tout_err), 32'(2'b10));
        chk("t4_ch1", lget(1, 0), 32'(8'h55));
        chk("t4_ch0_n", lg[0].size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t4_ch0", lget(0, i), 32'(8'hA0 + i));
        cyc(40);
        chk("t4_sticky", 32'(tout_err[1]), 32'(1));
        tr_st = 0;

        // push and pop on the same edge at count 2
        lclear();
        psg_rdy[1] = 1;
        cen_auto[1] = 0;
        cen_man[1] = 0;
        push_main(1, 8'h31, 1);
        push_main(1, 8'h32, 1);
        cyc(3);
        @(negedge clk);
        chk("t5_strobe", 32'(psg_cs_n[1]), 32'(0));
        @(posedge clk);
        #2;
        cen_man[1] = 1;
        cyc(1);
        cen_man[1] = 0;
        cyc(2);
        cen_man[1] = 1;
        cpu_dout = 8'h33;
        data_cs[1] = 1;
        wr_cs[1] = 1;
        cyc(1);
        cen_man[1] = 0;
        data_cs[1] = 0;
        wr_cs[1] = 0;
        @(negedge clk);
        chk("t5_coin", coin, 1);
        chk("t5_nfull", 32'(full[1]), 32'(0));
        chk("t5_nempty", 32'(empty[1]), 32'(0));
        @(posedge clk);
        #2;
        push_main(1, 8'h34, 1);
        @(negedge clk);
        chk("t5_cnt3", 32'(full[1]), 32'(0));
        @(posedge clk);
        #2;
        push_main(1, 8'h35, 1);
        @(negedge clk);
        chk("t5_cnt4", 32'(full[1]), 32'(1));
        @(posedge clk);
        #2;
        cen_auto[1] = 1;
        cyc(80);
        chk("t5_n", lg[1].size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t5_order", lget(1, i), 32'(8'h31 + i));

        // reset while busy discards the queue
        lclear();
        psg_rdy[0] = 0;
        push_main(0, 8'hC0, 1);
        push_main(0, 8'hC1, 1);
        push_main(0, 8'hC2, 1);
        cyc(10);
        @(negedge clk);
        chk("t6_busy", 32'({psg_cs_n[0], empty[0]}),
            32'(2'b10));
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk_reset("rst1");
        cyc(2);
        rst = 0;
        lclear();
        psg_rdy = 2'b11;
        cyc(40);
        chk("t6_quiet0", lowcnt[0], 0);
        chk("t6_quiet1", lowcnt[1], 0);
        push_main(0, 8'hEE, 0);
        cyc(15);
        chk("t6_hold0", lget(0, 0), 32'(8'h00));

        // DEPTH=2 pointer wrap over ten commands
        lclear();
        for (int i = 0; i < 10; i++)
            push_d2(8'(8'h10 + i));
        cyc(80);
        chk("d2_n", lg[2].size(), 10);
        for (int i = 0; i < 10; i++)
            chk("d2_order", lget(2, i), 32'(8'h10 + i));
        chk("d2_full_seen", 32'(d2_full_seen), 32'(1));
        chk("d2_empty", 32'(d2_empty[0]), 32'(1));
        chk("d2_err", 32'(d2_err[0]), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
